// File: rtl/bsg_manycore_mem_responder.sv
// Memory endpoint on a cache-side manycore link: executes one remote load/store/amoswap at a time
// against a local word array and returns a credit or int_wb packet on the rev network.
module bsg_manycore_mem_responder #(
  parameter int unsigned addr_width_p   = 16,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned mem_els_p      = 1024,
  localparam int unsigned mask_width_lp = data_width_p / 8,
  localparam int unsigned lg_mem_els_lp = $clog2(mem_els_p),
  localparam int unsigned fwd_width_lp  = addr_width_p + 4 + mask_width_lp + 5 + data_width_p
                                          + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int unsigned rev_width_lp  = 2 + data_width_p + 5 + x_cord_width_p + y_cord_width_p,
  localparam int unsigned link_sif_width_lp = fwd_width_lp + rev_width_lp + 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  output logic [31:0]                  req_count_o,
  output logic                         error_o
);

  localparam logic [3:0] e_remote_load    = 4'd0;
  localparam logic [3:0] e_remote_store   = 4'd1;
  localparam logic [3:0] e_remote_amoswap = 4'd2;
  localparam logic [1:0] e_return_credit  = 2'd0;
  localparam logic [1:0] e_return_int_wb  = 2'd1;

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [3:0]                op;
    logic [mask_width_lp-1:0]  op_ex;
    logic [4:0]                reg_id;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] dst_y;
    logic [x_cord_width_p-1:0] dst_x;
  } fwd_pkt_t;

  typedef struct packed {
    logic [1:0]                pkt_type;
    logic [data_width_p-1:0]   data;
    logic [4:0]                reg_id;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } rev_pkt_t;

  typedef struct packed {
    logic     v;
    fwd_pkt_t data;
    logic     ready_and_rev;
  } fwd_link_t;

  typedef struct packed {
    logic     v;
    rev_pkt_t data;
    logic     ready_and_rev;
  } rev_link_t;

  typedef struct packed {
    fwd_link_t fwd;
    rev_link_t rev;
  } link_sif_t;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  link_sif_t link_in, link_out;
  assign link_in    = link_sif_i;
  assign link_sif_o = link_out;

  state_e   state_q, state_d;
  fwd_pkt_t req_q, req_d;
  rev_pkt_t resp_q, resp_d;
  logic [31:0] count_q, count_d;
  logic error_q, error_d;
  logic fwd_ready;

  logic [data_width_p-1:0] mem [mem_els_p];
  logic [lg_mem_els_lp-1:0] idx;
  logic [data_width_p-1:0] mem_rdata, mem_wdata;
  logic mem_we;

  // Upper address bits alias onto the array without complaint.
  assign idx       = req_q.addr[lg_mem_els_lp-1:0];
  assign mem_rdata = mem[idx];

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    resp_d    = resp_q;
    count_d   = count_q;
    error_d   = error_q;
    fwd_ready = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = mem_rdata;
    unique case (state_q)
      StIdle: begin
        fwd_ready = 1'b1;
        if (link_in.fwd.v) begin
          req_d   = link_in.fwd.data;
          count_d = count_q + 32'd1;
          state_d = StExec;
        end
      end
      StExec: begin
        resp_d.x_cord   = req_q.src_x;
        resp_d.y_cord   = req_q.src_y;
        resp_d.reg_id   = req_q.reg_id;
        resp_d.pkt_type = e_return_credit;
        resp_d.data     = '0;
        case (req_q.op)
          e_remote_load: begin
            resp_d.pkt_type = e_return_int_wb;
            resp_d.data     = mem_rdata;
          end
          e_remote_store: begin
            mem_we = |req_q.op_ex;
            for (int b = 0; b < int'(mask_width_lp); b++) begin
              if (req_q.op_ex[b]) mem_wdata[8*b+:8] = req_q.payload[8*b+:8];
            end
          end
          e_remote_amoswap: begin
            mem_we          = 1'b1;
            mem_wdata       = req_q.payload;
            resp_d.pkt_type = e_return_int_wb;
            resp_d.data     = mem_rdata;
          end
          default: error_d = 1'b1;
        endcase
        if (req_q.dst_x != my_x_i || req_q.dst_y != my_y_i) error_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (link_in.rev.ready_and_rev) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      req_q   <= '0;
      resp_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx] <= mem_wdata;
  end

  always_comb begin
    link_out                   = '0;
    link_out.fwd.ready_and_rev = fwd_ready & reset_n_i;
    link_out.rev.v             = (state_q == StResp);
    link_out.rev.data          = resp_q;
  end

  assign req_count_o = count_q;
  assign error_o     = error_q;

  logic unused_bits;
  assign unused_bits = ^{link_in.fwd.ready_and_rev, link_in.rev.v, link_in.rev.data, req_q.addr};

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Bench for bsg_manycore_mem_responder: directed vector table, backpressure and reset corners,
// then randomized traffic checked against a word-array reference model.
module tb_bsg_manycore_mem_responder;

  localparam logic [3:0] OpLoad  = 4'd0;
  localparam logic [3:0] OpStore = 4'd1;
  localparam logic [3:0] OpAmo   = 4'd2;
  localparam logic [3:0] OpBad   = 4'hF;
  localparam logic [1:0] RetCredit = 2'd0;
  localparam logic [1:0] RetWb     = 2'd1;
  localparam logic [3:0] MyX = 4'd3;
  localparam logic [3:0] MyY = 4'd2;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  op;
    logic [3:0]  op_ex;
    logic [4:0]  reg_id;
    logic [31:0] payload;
    logic [3:0]  src_y;
    logic [3:0]  src_x;
    logic [3:0]  dst_y;
    logic [3:0]  dst_x;
  } fwd_pkt_t;

  typedef struct packed {
    logic [1:0]  pkt_type;
    logic [31:0] data;
    logic [4:0]  reg_id;
    logic [3:0]  y_cord;
    logic [3:0]  x_cord;
  } rev_pkt_t;

  typedef struct packed {
    logic v; fwd_pkt_t data; logic ready_and_rev;
    logic rv; rev_pkt_t rdata; logic rready;
  } link_sif_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  dst_x;
    logic [1:0]  exp_type;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        fwd_v = 1'b0;
  fwd_pkt_t    fwd_data = '0;
  logic        rev_ready = 1'b0;
  logic [127:0] link_sif_i, link_sif_o;
  link_sif_t   lout;
  logic [31:0] req_count;
  logic        error;

  assign link_sif_i = {fwd_v, fwd_data, 1'b0, 1'b0, 47'd0, rev_ready};
  assign lout = link_sif_o;

  bsg_manycore_mem_responder dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .link_sif_i  (link_sif_i),
    .link_sif_o  (link_sif_o),
    .my_x_i      (MyX),
    .my_y_i      (MyY),
    .req_count_o (req_count),
    .error_o     (error)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mmem [1024];
  int unsigned m_count;
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fwd_pkt_t mk(input logic [3:0] op, input logic [15:0] addr,
                                  input logic [3:0] mask, input logic [31:0] data,
                                  input logic [3:0] dst_x, input logic [3:0] dst_y,
                                  input logic [4:0] reg_id, input logic [3:0] sx,
                                  input logic [3:0] sy);
    fwd_pkt_t p;
    p.addr = addr; p.op = op; p.op_ex = mask; p.reg_id = reg_id; p.payload = data;
    p.src_y = sy; p.src_x = sx; p.dst_y = dst_y; p.dst_x = dst_x;
    return p;
  endfunction

  task automatic transact(input fwd_pkt_t p, input int stall, output rev_pkt_t r);
    int n;
    r = '0;
    @(negedge clk_i);
    fwd_v = 1'b1;
    fwd_data = p;
    n = 0;
    while (lout.ready_and_rev !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("fwd_ready_timeout", 64'(n < 20), 64'd1);
    @(negedge clk_i);
    fwd_v = 1'b0;
    chk("exec_rev_v", 64'(lout.rv), 64'd0);
    chk("exec_fwd_ready", 64'(lout.ready_and_rev), 64'd0);
    @(negedge clk_i);
    chk("latency_rev_v", 64'(lout.rv), 64'd1);
    n = 0;
    while (lout.rv !== 1'b1 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    r = lout.rdata;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_i);
      chk("stall_rev_v", 64'(lout.rv), 64'd1);
      chk("stall_rev_data", 64'(lout.rdata), 64'(r));
      chk("stall_fwd_ready", 64'(lout.ready_and_rev), 64'd0);
    end
    rev_ready = 1'b1;
    @(negedge clk_i);
    rev_ready = 1'b0;
    chk("post_rev_v", 64'(lout.rv), 64'd0);
    chk("post_fwd_ready", 64'(lout.ready_and_rev), 64'd1);
  endtask

  vec_t tbl [13];

  initial begin
    rev_pkt_t r;
    fwd_pkt_t p;

    tbl[0]  = '{OpStore, 16'h0005, 4'hF, 32'hDEADBEEF, MyX, RetCredit, 32'h0, 1'b0};
    tbl[1]  = '{OpLoad,  16'h0005, 4'h0, 32'h0,        MyX, RetWb, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{OpStore, 16'h0006, 4'hF, 32'h11223344, MyX, RetCredit, 32'h0, 1'b0};
    tbl[3]  = '{OpStore, 16'h0006, 4'h1, 32'h000000AA, MyX, RetCredit, 32'h0, 1'b0};
    tbl[4]  = '{OpLoad,  16'h0006, 4'h0, 32'h0,        MyX, RetWb, 32'h112233AA, 1'b0};
    tbl[5]  = '{OpStore, 16'h0007, 4'hF, 32'h00000001, MyX, RetCredit, 32'h0, 1'b0};
    tbl[6]  = '{OpAmo,   16'h0007, 4'hF, 32'h00000002, MyX, RetWb, 32'h00000001, 1'b0};
    tbl[7]  = '{OpLoad,  16'h0007, 4'h3, 32'h0,        MyX, RetWb, 32'h00000002, 1'b0};
    tbl[8]  = '{OpStore, 16'h1005, 4'h0, 32'h0,        MyX, RetCredit, 32'h0, 1'b0};
    tbl[9]  = '{OpLoad,  16'h0405, 4'h0, 32'h0,        MyX, RetWb, 32'hDEADBEEF, 1'b0};
    tbl[10] = '{OpBad,   16'h0005, 4'hF, 32'hFFFFFFFF, MyX, RetCredit, 32'h0, 1'b1};
    tbl[11] = '{OpLoad,  16'h0005, 4'h0, 32'h0,   4'd4, RetWb, 32'hDEADBEEF, 1'b1};
    tbl[12] = '{OpLoad,  16'h0005, 4'h0, 32'h0,        MyX, RetWb, 32'hDEADBEEF, 1'b1};

    repeat (3) @(negedge clk_i);
    chk("rst_rev_v", 64'(lout.rv), 64'd0);
    chk("rst_fwd_ready", 64'(lout.ready_and_rev), 64'd0);
    chk("rst_count", 64'(req_count), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle_fwd_ready", 64'(lout.ready_and_rev), 64'd1);
    chk("tie_fwd_v", 64'(lout.v), 64'd0);
    chk("tie_fwd_data", 64'(lout.data), 64'd0);
    chk("tie_rev_ready", 64'(lout.rready), 64'd0);

    for (int i = 0; i < 13; i++) begin
      p = mk(tbl[i].op, tbl[i].addr, tbl[i].mask, tbl[i].data, tbl[i].dst_x, MyY,
             5'(i), 4'(i), 4'(15 - i));
      transact(p, 0, r);
      chk($sformatf("tbl%0d_type", i), 64'(r.pkt_type), 64'(tbl[i].exp_type));
      chk($sformatf("tbl%0d_data", i), 64'(r.data), 64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_dest", i), 64'({r.reg_id, r.y_cord, r.x_cord}),
          64'({5'(i), 4'(15 - i), 4'(i)}));
      chk($sformatf("tbl%0d_error", i), 64'(error), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_count", i), 64'(req_count), 64'(i + 1));
    end

    // Ten cycles of rev backpressure.
    transact(mk(OpLoad, 16'h0005, 4'h0, 32'h0, MyX, MyY, 5'd9, 4'd1, 4'd1), 10, r);
    chk("bp_data", 64'(r.data), 64'hDEADBEEF);
    chk("bp_count", 64'(req_count), 64'd14);

    // Reset while a response is pending.
    transact(mk(OpStore, 16'h0009, 4'hF, 32'hCAFEF00D, MyX, MyY, 5'd1, 4'd1, 4'd1), 0, r);
    @(negedge clk_i);
    fwd_v = 1'b1;
    fwd_data = mk(OpLoad, 16'h0009, 4'h0, 32'h0, MyX, MyY, 5'd2, 4'd1, 4'd1);
    @(negedge clk_i);
    fwd_v = 1'b0;
    @(negedge clk_i);
    chk("resp_before_rst", 64'(lout.rv), 64'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("midrst_rev_v", 64'(lout.rv), 64'd0);
    chk("midrst_fwd_ready", 64'(lout.ready_and_rev), 64'd0);
    chk("midrst_count", 64'(req_count), 64'd0);
    chk("midrst_error", 64'(error), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    transact(mk(OpLoad, 16'h0009, 4'h0, 32'h0, MyX, MyY, 5'd3, 4'd1, 4'd1), 0, r);
    chk("retain_data", 64'(r.data), 64'hCAFEF00D);
    chk("retain_count", 64'(req_count), 64'd1);

    // Randomized traffic against the reference model.
    m_count = 1;
    m_err = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mmem[i] = $urandom;
      transact(mk(OpStore, 16'(i), 4'hF, mmem[i], MyX, MyY, 5'd0, 4'd0, 4'd0), 0, r);
      m_count++;
    end
    for (int i = 0; i < 200; i++) begin
      int          sel;
      int unsigned ix;
      logic [3:0]  op, mask, dy;
      logic [31:0] d, exp_d;
      logic [1:0]  exp_t;
      sel  = $urandom_range(0, 9);
      ix   = $urandom_range(0, 31);
      mask = 4'($urandom);
      d    = $urandom;
      dy   = MyY;
      op   = (sel < 3) ? OpLoad : (sel < 6) ? OpStore : (sel < 8) ? OpAmo :
             (sel == 8) ? 4'($urandom_range(3, 14)) : OpLoad;
      if (sel == 9) dy = MyY + 4'd1;
      exp_t = RetCredit;
      exp_d = 32'h0;
      if (op == OpLoad) begin
        exp_t = RetWb;
        exp_d = mmem[ix];
      end else if (op == OpStore) begin
        for (int b = 0; b < 4; b++) if (mask[b]) mmem[ix][8*b+:8] = d[8*b+:8];
      end else if (op == OpAmo) begin
        exp_t = RetWb;
        exp_d = mmem[ix];
        mmem[ix] = d;
      end else begin
        m_err = 1'b1;
      end
      if (dy != MyY) m_err = 1'b1;
      m_count++;
      p = mk(op, {6'($urandom), 10'(ix)}, mask, d, MyX, dy, 5'($urandom), 4'($urandom),
             4'($urandom));
      transact(p, $urandom_range(0, 3), r);
      chk($sformatf("rnd%0d_type", i), 64'(r.pkt_type), 64'(exp_t));
      chk($sformatf("rnd%0d_data", i), 64'(r.data), 64'(exp_d));
      chk($sformatf("rnd%0d_dest", i), 64'({r.reg_id, r.y_cord, r.x_cord}),
          64'({p.reg_id, p.src_y, p.src_x}));
      chk($sformatf("rnd%0d_error", i), 64'(error), 64'(m_err));
      chk($sformatf("rnd%0d_count", i), 64'(req_count), 64'(m_count));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
